// File: rtl/rv32_pipe_core.sv
// rv32_pipe_core: five-stage in-order RV32I-subset core with on-chip memories.
// Define RV32_MUL_EN to execute mul; otherwise funct7=0000001 decodes as NOP.
module rv32_pipe_core #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLL,
    A_SRL, A_SRA, A_SLT, A_MUL, A_LNK
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    alu_op_e     op;
    logic        use_imm, rw, mr, mw, jr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } mem_wb_t;

  logic [31:0] imem    [IMEM_WORDS];
  logic [31:0] dmem    [DMEM_WORDS];
  logic [31:0] regfile [32];
  logic [31:0] pc;

  if_id_t  if_id;
  id_ex_t  id_ex, dec;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic [31:0] fetch, ir, rv1, rv2, br_a, br_b, tgt;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, is_br, is_jal, ok;
  logic        wb_we, em_h1, em_h2, ie_h1, ie_h2;
  logic        lu_stall, br_stall, stall, taken;
  logic        em_f1, em_f2, wb_f1, wb_f2;
  logic [31:0] fa, fb, opb, alu_res, jr_tgt, ld, wb_res;

  assign fetch = imem[pc[IAW+1:2]];
  assign ir    = if_id.ir;
  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign f7    = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  // regfile read bypasses the write happening this cycle
  assign wb_we = mem_wb.rw && (mem_wb.rd != 5'd0);
  assign rv1 = (rs1 == 5'd0) ? 32'd0 :
               (wb_we && mem_wb.rd == rs1) ? mem_wb.res :
               regfile[rs1];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 :
               (wb_we && mem_wb.rd == rs2) ? mem_wb.res :
               regfile[rs2];

  always_comb begin
    dec     = '0;
    dec.pc  = if_id.pc;
    dec.a   = rv1;
    dec.b   = rv2;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
    use1    = 1'b0;
    use2    = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    ok      = 1'b0;
    case (opc)
      7'b0110011: begin
        use1 = 1'b1; use2 = 1'b1;
        dec.rd = rd; dec.rw = 1'b1; ok = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec.op = A_ADD;
          10'b0100000_000: dec.op = A_SUB;
          10'b0000000_111: dec.op = A_AND;
          10'b0000000_110: dec.op = A_OR;
          10'b0000000_100: dec.op = A_XOR;
          10'b0000000_001: dec.op = A_SLL;
          10'b0000000_101: dec.op = A_SRL;
          10'b0100000_101: dec.op = A_SRA;
          10'b0000000_010: dec.op = A_SLT;
`ifdef RV32_MUL_EN
          10'b0000001_000: dec.op = A_MUL;
`endif
          default: ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        use1 = 1'b1; dec.rd = rd; dec.rw = 1'b1;
        dec.use_imm = 1'b1; dec.imm = imm_i; ok = 1'b1;
        case (f3)
          3'b000: dec.op = A_ADD;
          3'b111: dec.op = A_AND;
          3'b110: dec.op = A_OR;
          3'b100: dec.op = A_XOR;
          3'b001: begin
            dec.op = A_SLL; ok = (f7 == 7'b0000000);
          end
          3'b101: begin
            dec.op = f7[5] ? A_SRA : A_SRL;
            ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          end
          default: ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        use1 = 1'b1; dec.rd = rd; dec.rw = 1'b1; dec.mr = 1'b1;
        dec.use_imm = 1'b1; dec.imm = imm_i; ok = (f3 == 3'b010);
      end
      7'b0100011: begin
        use1 = 1'b1; use2 = 1'b1; dec.mw = 1'b1;
        dec.use_imm = 1'b1; dec.imm = imm_s; ok = (f3 == 3'b010);
      end
      7'b1100011: begin
        use1 = 1'b1; use2 = 1'b1; is_br = 1'b1;
        ok = (f3[2:1] == 2'b00);
      end
      7'b1101111: begin
        is_jal = 1'b1; dec.rd = rd; dec.rw = 1'b1;
        dec.op = A_LNK; ok = 1'b1;
      end
      7'b1100111: begin
        use1 = 1'b1; dec.rd = rd; dec.rw = 1'b1; dec.jr = 1'b1;
        dec.op = A_LNK; dec.imm = imm_i; ok = (f3 == 3'b000);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      dec.rd = '0; dec.rw = 1'b0; dec.mr = 1'b0;
      dec.mw = 1'b0; dec.jr = 1'b0;
      use1 = 1'b0; use2 = 1'b0; is_br = 1'b0; is_jal = 1'b0;
    end
  end

  assign ie_h1 = id_ex.rw && id_ex.rd != 5'd0 && id_ex.rd == rs1;
  assign ie_h2 = id_ex.rw && id_ex.rd != 5'd0 && id_ex.rd == rs2;
  assign em_h1 = ex_mem.rw && ex_mem.rd != 5'd0 && ex_mem.rd == rs1;
  assign em_h2 = ex_mem.rw && ex_mem.rd != 5'd0 && ex_mem.rd == rs2;

  // branches compare in ID; only a finished ALU result can be forwarded
  assign br_a = em_h1 ? ex_mem.res : rv1;
  assign br_b = em_h2 ? ex_mem.res : rv2;
  assign lu_stall = id_ex.mr && ((use1 && ie_h1) || (use2 && ie_h2));
  assign br_stall = is_br && (ie_h1 || ie_h2 ||
                    (ex_mem.mr && (em_h1 || em_h2)));
  assign stall = lu_stall || br_stall;
  assign taken = is_jal || (is_br && ((br_a == br_b) ^ f3[0]));
  assign tgt   = if_id.pc + (is_jal ? imm_j : imm_b);

  assign em_f1 = ex_mem.rw && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1;
  assign em_f2 = ex_mem.rw && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2;
  assign wb_f1 = wb_we && mem_wb.rd == id_ex.rs1;
  assign wb_f2 = wb_we && mem_wb.rd == id_ex.rs2;
  assign fa  = em_f1 ? ex_mem.res : wb_f1 ? mem_wb.res : id_ex.a;
  assign fb  = em_f2 ? ex_mem.res : wb_f2 ? mem_wb.res : id_ex.b;
  assign opb = id_ex.use_imm ? id_ex.imm : fb;
  assign jr_tgt = (fa + id_ex.imm) & ~32'd1;

  always_comb begin
    alu_res = fa + opb;
    case (id_ex.op)
      A_SUB: alu_res = fa - opb;
      A_AND: alu_res = fa & opb;
      A_OR:  alu_res = fa | opb;
      A_XOR: alu_res = fa ^ opb;
      A_SLL: alu_res = fa << opb[4:0];
      A_SRL: alu_res = fa >> opb[4:0];
      A_SRA: alu_res = $unsigned($signed(fa) >>> opb[4:0]);
      A_SLT: alu_res = {31'd0, $signed(fa) < $signed(opb)};
`ifdef RV32_MUL_EN
      A_MUL: alu_res = fa * opb;
`endif
      A_LNK: alu_res = id_ex.pc + 32'd4;
      default: ;
    endcase
  end

  assign ld     = dmem[ex_mem.res[DAW+1:2]];
  assign wb_res = ex_mem.mr ? ld : ex_mem.res;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc     <= RESET_PC;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (start_i) begin
      ex_mem <= '{res: alu_res, sd: fb, rd: id_ex.rd,
                  rw: id_ex.rw, mr: id_ex.mr, mw: id_ex.mw};
      mem_wb <= '{res: wb_res, rd: ex_mem.rd, rw: ex_mem.rw};
      if (id_ex.jr) begin
        pc    <= jr_tgt;
        if_id <= '0;
        id_ex <= '0;
      end else if (stall) begin
        id_ex <= '0;
      end else if (taken) begin
        pc    <= tgt;
        if_id <= '0;
        id_ex <= dec;
      end else begin
        pc    <= pc + 32'd4;
        if_id <= '{pc: pc, ir: fetch};
        id_ex <= dec;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && start_i) begin
      if (wb_we) regfile[mem_wb.rd] <= mem_wb.res;
      if (ex_mem.mw) dmem[ex_mem.res[DAW+1:2]] <= ex_mem.sd;
    end
  end
endmodule

// File: tb/tb_rv32_pipe_core.sv
// tb_rv32_pipe_core: directed programs loaded into imem,
// results checked through the PC, regfile and dmem.
module tb_rv32_pipe_core;
  typedef logic [31:0] w_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   total = 0;
  int   bad = 0;
  int   wp = 0;

  always #5 clk = ~clk;

  rv32_pipe_core dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start)
  );

  function automatic w_t enc_i(w_t op, w_t f3, w_t rd, w_t rs1, w_t imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic w_t rr(w_t f7, w_t f3, w_t rd, w_t rs1, w_t rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic w_t sw(w_t rs2, w_t rs1, w_t imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic w_t br(w_t f3, w_t rs1, w_t rs2, w_t imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
            imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic w_t jal(w_t rd, w_t imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic w_t addi(w_t rd, w_t rs1, w_t imm);
    return enc_i(32'h13, 0, rd, rs1, imm);
  endfunction
  function automatic w_t lw(w_t rd, w_t rs1, w_t imm);
    return enc_i(32'h03, 2, rd, rs1, imm);
  endfunction
  function automatic w_t jalr(w_t rd, w_t rs1, w_t imm);
    return enc_i(32'h67, 0, rd, rs1, imm);
  endfunction

  task automatic clr();
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    wp = 0;
  endtask
  task automatic put(input w_t v);
    dut.imem[wp] = v;
    wp++;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    run(1);
    total++;
    if (dut.pc !== 32'h0) begin
      bad++; $display("FAIL reset_pc got=%h want=0", dut.pc);
    end
    total++;
    if ({dut.id_ex.rw, dut.ex_mem.rw, dut.mem_wb.rw,
         dut.ex_mem.mw, dut.ex_mem.mr} !== 5'b0) begin
      bad++; $display("FAIL reset_nop pipeline not cleared");
    end
    total++;
    if (dut.if_id.ir !== 32'h0) begin
      bad++; $display("FAIL reset_ifid got=%h want=0", dut.if_id.ir);
    end
  endtask

  task automatic test_alu_fwd();
    clr();
    put(addi(1, 0, 5));
    put(addi(2, 0, 3));
    put(rr(0, 0, 3, 1, 2));
    do_reset();
    run(6);
    total++;
    if (dut.pc !== 32'd24) begin
      bad++; $display("FAIL alu_pc got=%0d want=24", dut.pc);
    end
    run(6);
    total++;
    if (dut.regfile[3] !== 32'd8) begin
      bad++; $display("FAIL alu_x3 got=%0d want=8", dut.regfile[3]);
    end
  endtask

  task automatic test_alu_ops();
    w_t exp [16] = '{32'hFFFFFFED, 32'h0, 32'hFFFFFFF3, 32'hFFFFFFF3,
                     32'hFFFFFF80, 32'h1FFFFFFE, 32'hFFFFFFFE, 32'h1,
                     32'h0, 32'hFFFFFFFC, 32'hF, 32'h30,
                     32'hF0, 32'h703, 32'hFFFFFFFC, 32'h3};
    clr();
    put(addi(1, 0, -16));
    put(addi(2, 0, 3));
    put(rr(32, 0, 3, 1, 2));
    put(rr(0, 7, 4, 1, 2));
    put(rr(0, 6, 5, 1, 2));
    put(rr(0, 4, 6, 1, 2));
    put(rr(0, 1, 7, 1, 2));
    put(rr(0, 5, 8, 1, 2));
    put(rr(32, 5, 9, 1, 2));
    put(rr(0, 2, 10, 1, 2));
    put(rr(0, 2, 11, 2, 1));
    put(enc_i(32'h13, 5, 12, 1, 32'h402));
    put(enc_i(32'h13, 5, 13, 1, 28));
    put(enc_i(32'h13, 1, 14, 2, 4));
    put(enc_i(32'h13, 7, 15, 1, 32'hFF));
    put(enc_i(32'h13, 6, 16, 2, 32'h700));
    put(enc_i(32'h13, 4, 17, 2, -1));
    put(rr(0, 0, 0, 1, 2));
    put(rr(0, 0, 18, 0, 2));
    do_reset();
    run(30);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dut.regfile[i+3] !== exp[i]) begin
        bad++;
        $display("FAIL ops_x%0d got=%h want=%h",
                 i + 3, dut.regfile[i+3], exp[i]);
      end
    end
  endtask

  task automatic test_load_use();
    clr();
    put(addi(10, 0, 5));
    put(sw(10, 0, 0));
    put(lw(4, 0, 0));
    put(rr(0, 0, 5, 4, 4));
    do_reset();
    run(4);
    total++;
    if (dut.pc !== 32'd16) begin
      bad++; $display("FAIL lu_pc4 got=%0d want=16", dut.pc);
    end
    run(1);
    total++;
    if (dut.pc !== 32'd16) begin
      bad++; $display("FAIL lu_hold got=%0d want=16", dut.pc);
    end
    run(1);
    total++;
    if (dut.pc !== 32'd20) begin
      bad++; $display("FAIL lu_pc6 got=%0d want=20", dut.pc);
    end
    run(10);
    total++;
    if (dut.regfile[5] !== 32'd10) begin
      bad++; $display("FAIL lu_x5 got=%0d want=10", dut.regfile[5]);
    end
    total++;
    if (dut.dmem[0] !== 32'd5) begin
      bad++; $display("FAIL lu_dmem0 got=%0d want=5", dut.dmem[0]);
    end
  endtask

  task automatic test_store_load();
    clr();
    put(addi(3, 0, 8));
    put(sw(3, 0, 4));
    put(lw(6, 0, 4));
    put(lw(7, 0, 7));
    do_reset();
    run(15);
    total++;
    if (dut.dmem[1] !== 32'd8) begin
      bad++; $display("FAIL sl_dmem1 got=%0d want=8", dut.dmem[1]);
    end
    total++;
    if (dut.regfile[6] !== 32'd8) begin
      bad++; $display("FAIL sl_x6 got=%0d want=8", dut.regfile[6]);
    end
    total++;
    if (dut.regfile[7] !== 32'd8) begin
      bad++; $display("FAIL sl_x7_offs got=%0d want=8", dut.regfile[7]);
    end
  endtask

  task automatic test_branch();
    w_t exp [5] = '{32'd0, 32'd2, 32'd4, 32'd0, 32'd1};
    int idx [5] = '{7, 8, 9, 12, 13};
    clr();
    put(addi(7, 0, 0));
    put(addi(12, 0, 0));
    put(addi(1, 0, 1));
    put(br(0, 1, 1, 8));
    put(addi(7, 0, 9));
    put(addi(8, 0, 2));
    put(br(1, 1, 1, 8));
    put(addi(9, 0, 4));
    put(br(1, 1, 0, 8));
    put(addi(12, 0, 7));
    put(addi(13, 0, 1));
    do_reset();
    run(30);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut.regfile[idx[i]] !== exp[i]) begin
        bad++;
        $display("FAIL br_x%0d got=%0d want=%0d",
                 idx[i], dut.regfile[idx[i]], exp[i]);
      end
    end
  endtask

  task automatic test_jumps();
    clr();
    put(jal(1, 12));
    put(addi(20, 0, 7));
    put(jal(0, 0));
    put(addi(22, 0, 5));
    put(jalr(0, 1, 0));
    put(addi(3, 0, 99));
    put(addi(4, 0, 99));
    do_reset();
    run(2);
    total++;
    if (dut.pc !== 32'd12) begin
      bad++; $display("FAIL jal_pc got=%0d want=12", dut.pc);
    end
    run(4);
    total++;
    if (dut.pc !== 32'd4) begin
      bad++; $display("FAIL jalr_pc got=%0d want=4", dut.pc);
    end
    run(20);
    total++;
    if (dut.regfile[1] !== 32'd4) begin
      bad++; $display("FAIL jal_link got=%0d want=4", dut.regfile[1]);
    end
    total++;
    if (dut.regfile[20] !== 32'd7 || dut.regfile[22] !== 32'd5) begin
      bad++;
      $display("FAIL jmp_path x20=%0d want=7 x22=%0d want=5",
               dut.regfile[20], dut.regfile[22]);
    end
    total++;
    if (dut.regfile[3] !== 32'd8 || dut.regfile[4] !== 32'd5) begin
      bad++;
      $display("FAIL jalr_squash x3=%0d want=8 x4=%0d want=5",
               dut.regfile[3], dut.regfile[4]);
    end
  endtask

  task automatic test_stall_reset();
    clr();
    put(addi(27, 0, 11));
    put(addi(28, 0, 22));
    put(sw(28, 0, 12));
    put(addi(29, 0, 33));
    do_reset();
    run(3);
    start = 1'b0;
    run(5);
    total++;
    if (dut.pc !== 32'd12 || dut.if_id.pc !== 32'd8) begin
      bad++;
      $display("FAIL stall_pc pc=%0d want=12 ifid=%0d want=8",
               dut.pc, dut.if_id.pc);
    end
    total++;
    if (dut.ex_mem.rd !== 5'd27 || dut.id_ex.rd !== 5'd28) begin
      bad++;
      $display("FAIL stall_pipe exm=%0d want=27 idex=%0d want=28",
               dut.ex_mem.rd, dut.id_ex.rd);
    end
    start = 1'b1;
    run(2);
    total++;
    if (dut.regfile[27] !== 32'd11 || dut.pc !== 32'd20) begin
      bad++;
      $display("FAIL resume x27=%0d want=11 pc=%0d want=20",
               dut.regfile[27], dut.pc);
    end
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    start = 1'b0;
    total++;
    if (dut.pc !== 32'd0 || dut.mem_wb.rw !== 1'b0 ||
        dut.ex_mem.mw !== 1'b0 || dut.id_ex.rw !== 1'b0) begin
      bad++; $display("FAIL midrst pc=%0d want=0 or pipe not NOP", dut.pc);
    end
    total++;
    if (dut.regfile[28] === 32'd22 || dut.dmem[3] === 32'd22) begin
      bad++; $display("FAIL midrst_discard x28/dmem3 written=22 want=old");
    end
    total++;
    if (dut.regfile[27] !== 32'd11 || dut.dmem[1] !== 32'd8) begin
      bad++;
      $display("FAIL midrst_keep x27=%0d want=11 dmem1=%0d want=8",
               dut.regfile[27], dut.dmem[1]);
    end
  endtask

  task automatic test_mul();
    w_t exp9;
`ifdef RV32_MUL_EN
    exp9 = 32'd42;
`else
    exp9 = 32'd1;
`endif
    clr();
    put(addi(1, 0, 7));
    put(addi(2, 0, 6));
    put(addi(9, 0, 1));
    put(rr(1, 0, 9, 1, 2));
    do_reset();
    run(15);
    total++;
    if (dut.regfile[9] !== exp9) begin
      bad++; $display("FAIL mul_x9 got=%0d want=%0d", dut.regfile[9], exp9);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_alu_fwd();
    test_alu_ops();
    test_load_use();
    test_store_load();
    test_branch();
    test_jumps();
    test_stall_reset();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_pipe_core.md
Name: rv32_pipe_core

Overview:
- Five-stage in-order RV32I-subset core: IF, ID, EX, MEM, WB.
- Includes an on-chip instruction ROM, word-addressed data RAM, a 32x32 register file, full forwarding and load-use hazard detection.
- Top-level compute block of the design; no external bus.
- Observed by benches through hierarchical access to the PC, register file and memories.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 32-bit words.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  run enable; 0 freezes PC and all pipeline registers.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - PC=RESET_PC.
  - IF/ID, ID/EX, EX/MEM and MEM/WB load NOP: rd=0, reg-write=0, mem-write=0, mem-read=0.
  - Register file and both memories are not cleared.
  - Reset has priority over start_i; reset mid-run discards all in-flight instructions.
- Storage:
  - Internal arrays are named imem, regfile, dmem.
  - PC register value is pc (32 bits).
  - All are accessible hierarchically for preload and inspection.
- Stall: start_i=0 holds every stage register and the PC; no register or memory writes occur.
- IF: fetch imem[pc[9:2] mod IMEM_WORDS]; PC+=4 per cycle unless stalled or redirected.
- Decode: undefined opcodes, including the all-zero word, execute as NOP.
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, slt, mul.
  - I-type: addi, andi, ori, xori, slli, srli, srai.
  - Memory and control: lw, sw, beq, bne, jal, jalr.
- Arithmetic:
  - 32-bit, wrap-around; mul returns the low 32 bits.
  - Shifts use rs2[4:0] or shamt.
  - slt is a signed compare.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write occurs at the WB edge; a same-cycle read of the register being written returns the new value (internal bypass).
- Control flow:
  - Branches and jal resolve in ID; comparison uses forwarded operands.
  - When taken, the IF/ID instruction is squashed to NOP: 1 bubble.
  - Branch target = pc_ID + sext(imm).
  - jalr resolves in EX with target (rs1+imm)&~1; IF and ID are squashed: 2 bubbles.
  - jal and jalr write pc+4 to rd.
- Forwarding into EX, priority EX/MEM over MEM/WB; only from producers with reg-write=1 and rd!=0.
- Branch operands in ID:
  - Forwarded from EX/MEM.
  - An ALU producer in EX, or a load in EX/MEM, stalls ID one cycle.
- Load-use: lw in EX and a consumer in ID stalls PC and IF/ID for one cycle and inserts a NOP into EX.
- Data memory:
  - Word address = alu_result[11:2] mod DMEM_WORDS; byte offset is ignored.
  - sw writes at the MEM-stage edge; lw reads combinationally in MEM.
- Latency: result visible in regfile 5 rising edges after fetch with no hazards.
- Simultaneous events: load-use stall and a taken branch in the same cycle → stall wins; the branch re-evaluates next cycle.

Optional Feature:
- Macro: RV32_MUL_EN.
- Defined: mul (funct7=0000001, funct3=000) is executed.
- Undefined: any funct7=0000001 R-type decodes as NOP and writes nothing; multiplier is not synthesized.

Test Plan:
- Reset, dmem[0]=5, program "addi x1,x0,5; addi x2,x0,3; add x3,x1,x2" → x3=8 with no stall; pc=24 after 6 running cycles.
- "lw x4,0(x0); add x5,x4,x4" → x5=10; exactly one bubble inserted (PC holds one cycle).
- "addi x3,x0,8; sw x3,4(x0); lw x6,4(x0)" → dmem[1]=8, x6=8.
- "addi x1,x0,1; beq x1,x1,+8; addi x7,x0,9; addi x8,x0,2" → x7=0, x8=2; then bne not-taken → falls through.
- "jal x1,+12" at pc=0 → x1=4, next executed pc=12; "jalr x0,0(x1)" → pc=4, two squashed slots.
- start_i=0 for 5 cycles → pc and registers unchanged; then rst_i=1 mid-program → pc=0, pipeline NOPs, regfile/dmem retain values. With RV32_MUL_EN, "mul x9,x1,x2" with x1=7, x2=6 → x9=42; without it, x9 unchanged.
